render_frame_ctrl: RTL and testbench

- Frame-synchronous controller between game logic and the VGA renderer.
- Game logic writes a render parameter set through a valid/ready handshake into a shadow register set:
  - player position
  - bullet position, colour and enable
  - 32-bit game state word
- The block commits the shadow set to the active outputs driving the renderer only at vertical-blank entry, so a frame never mixes old and new parameters.
- It also produces a frame tick, a frame counter and a stale-frame counter for game-logic pacing.

---
 rtl/render_frame_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_render_frame_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/render_frame_ctrl.sv
// render_frame_ctrl: frame-synchronous parameter commit between game logic
// and the VGA renderer. Game logic fills a shadow set over a valid/ready
// handshake; the shadow is copied to the active outputs only at vblank
// entry, so a rendered frame never mixes old and new parameters. Also
// provides a frame tick, a wrapping frame counter and a saturating
// stale-frame counter for game-logic pacing.
module render_frame_ctrl #(
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned FCNT_W    = 8,
  parameter int unsigned STALE_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [9:0]         y,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [15:0]        wr_player_pos,
  input  logic [15:0]        wr_bullet_pos,
  input  logic [1:0]         wr_bullet_color,
  input  logic               wr_is_render,
  input  logic [31:0]        wr_state,
  output logic [15:0]        act_player_pos,
  output logic [15:0]        act_bullet_pos,
  output logic [1:0]         act_bullet_color,
  output logic               act_is_render,
  output logic [31:0]        act_state,
  output logic               pending,
  output logic               frame_tick,
  output logic [FCNT_W-1:0]  frame_cnt,
  output logic [STALE_W-1:0] stale_cnt
);

  localparam logic [9:0] V_DISP_Y = 10'(V_DISPLAY);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_FULL   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [9:0]           y_prev_q, y_prev_d;

  // Shadow set written by game logic
  logic [15:0]          sh_player_pos_q, sh_player_pos_d;
  logic [15:0]          sh_bullet_pos_q, sh_bullet_pos_d;
  logic [1:0]           sh_bullet_color_q, sh_bullet_color_d;
  logic                 sh_is_render_q, sh_is_render_d;
  logic [31:0]          sh_state_q, sh_state_d;

  // Active set seen by the renderer
  logic [15:0]          act_player_pos_q, act_player_pos_d;
  logic [15:0]          act_bullet_pos_q, act_bullet_pos_d;
  logic [1:0]           act_bullet_color_q, act_bullet_color_d;
  logic                 act_is_render_q, act_is_render_d;
  logic [31:0]          act_state_q, act_state_d;

  logic                 pending_q, pending_d;
  logic                 frame_tick_q, frame_tick_d;
  logic [FCNT_W-1:0]    frame_cnt_q, frame_cnt_d;
  logic [STALE_W-1:0]   stale_cnt_q, stale_cnt_d;

  logic                 vb_edge;
  logic                 transfer;

  // Vblank entry detection and handshake; writes are refused on the edge
  // cycle so a write can never collide with a commit.
  always_comb begin
    vb_edge  = (y_prev_q < V_DISP_Y) && (y >= V_DISP_Y);
    wr_ready = !vb_edge;
    transfer = wr_valid && wr_ready;
  end

  // Next-state logic for FSM, shadow/active sets and counters
  always_comb begin
    state_d            = state_q;
    y_prev_d           = y;
    sh_player_pos_d    = sh_player_pos_q;
    sh_bullet_pos_d    = sh_bullet_pos_q;
    sh_bullet_color_d  = sh_bullet_color_q;
    sh_is_render_d     = sh_is_render_q;
    sh_state_d         = sh_state_q;
    act_player_pos_d   = act_player_pos_q;
    act_bullet_pos_d   = act_bullet_pos_q;
    act_bullet_color_d = act_bullet_color_q;
    act_is_render_d    = act_is_render_q;
    act_state_d        = act_state_q;
    pending_d          = pending_q;
    frame_tick_d       = vb_edge;
    frame_cnt_d        = frame_cnt_q;
    stale_cnt_d        = stale_cnt_q;

    if (vb_edge) begin
      frame_cnt_d = frame_cnt_q + FCNT_W'(1);
    end

    // Last write wins: any accepted set simply overwrites the shadow.
    if (transfer) begin
      sh_player_pos_d   = wr_player_pos;
      sh_bullet_pos_d   = wr_bullet_pos;
      sh_bullet_color_d = wr_bullet_color;
      sh_is_render_d    = wr_is_render;
      sh_state_d        = wr_state;
      pending_d         = 1'b1;
    end

    case (state_q)
      ST_EMPTY: begin
        if (transfer) begin
          state_d = ST_FULL;
        end else if (vb_edge) begin
          if (stale_cnt_q != '1) begin
            stale_cnt_d = stale_cnt_q + STALE_W'(1);
          end
        end
      end

      ST_FULL: begin
        // transfer and vb_edge are mutually exclusive (wr_ready = !vb_edge)
        if (vb_edge) begin
          act_player_pos_d   = sh_player_pos_q;
          act_bullet_pos_d   = sh_bullet_pos_q;
          act_bullet_color_d = sh_bullet_color_q;
          act_is_render_d    = sh_is_render_q;
          act_state_d        = sh_state_q;
          pending_d          = 1'b0;
          stale_cnt_d        = '0;
          state_d            = ST_COMMIT;
        end
      end

      ST_COMMIT: begin
        if (transfer) begin
          state_d = ST_FULL;
        end else begin
          state_d = ST_EMPTY;
          if (vb_edge && (stale_cnt_q != '1)) begin
            stale_cnt_d = stale_cnt_q + STALE_W'(1);
          end
        end
      end

      default: begin
        state_d   = ST_EMPTY;
        pending_d = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous active-high reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q            <= ST_EMPTY;
      y_prev_q           <= V_DISP_Y;
      sh_player_pos_q    <= '0;
      sh_bullet_pos_q    <= '0;
      sh_bullet_color_q  <= '0;
      sh_is_render_q     <= 1'b0;
      sh_state_q         <= '0;
      act_player_pos_q   <= '0;
      act_bullet_pos_q   <= '0;
      act_bullet_color_q <= '0;
      act_is_render_q    <= 1'b0;
      act_state_q        <= '0;
      pending_q          <= 1'b0;
      frame_tick_q       <= 1'b0;
      frame_cnt_q        <= '0;
      stale_cnt_q        <= '0;
    end else begin
      state_q            <= state_d;
      y_prev_q           <= y_prev_d;
      sh_player_pos_q    <= sh_player_pos_d;
      sh_bullet_pos_q    <= sh_bullet_pos_d;
      sh_bullet_color_q  <= sh_bullet_color_d;
      sh_is_render_q     <= sh_is_render_d;
      sh_state_q         <= sh_state_d;
      act_player_pos_q   <= act_player_pos_d;
      act_bullet_pos_q   <= act_bullet_pos_d;
      act_bullet_color_q <= act_bullet_color_d;
      act_is_render_q    <= act_is_render_d;
      act_state_q        <= act_state_d;
      pending_q          <= pending_d;
      frame_tick_q       <= frame_tick_d;
      frame_cnt_q        <= frame_cnt_d;
      stale_cnt_q        <= stale_cnt_d;
    end
  end

  assign act_player_pos   = act_player_pos_q;
  assign act_bullet_pos   = act_bullet_pos_q;
  assign act_bullet_color = act_bullet_color_q;
  assign act_is_render    = act_is_render_q;
  assign act_state        = act_state_q;
  assign pending          = pending_q;
  assign frame_tick       = frame_tick_q;
  assign frame_cnt        = frame_cnt_q;
  assign stale_cnt        = stale_cnt_q;

endmodule

// File: tb/tb_render_frame_ctrl.sv
// Testbench for render_frame_ctrl: stimulus pushes the expected post-vblank
// state into a scoreboard queue; a monitor pops and compares on every
// frame_tick and flags any active-output change outside a tick.
module tb_render_frame_ctrl;

  logic        clk;
  logic        reset;
  logic [9:0]  y;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_player_pos;
  logic [15:0] wr_bullet_pos;
  logic [1:0]  wr_bullet_color;
  logic        wr_is_render;
  logic [31:0] wr_state;
  logic [15:0] act_player_pos;
  logic [15:0] act_bullet_pos;
  logic [1:0]  act_bullet_color;
  logic        act_is_render;
  logic [31:0] act_state;
  logic        pending;
  logic        frame_tick;
  logic [7:0]  frame_cnt;
  logic [3:0]  stale_cnt;

  render_frame_ctrl #(
    .V_DISPLAY(480),
    .FCNT_W   (8),
    .STALE_W  (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .y               (y),
    .wr_valid        (wr_valid),
    .wr_ready        (wr_ready),
    .wr_player_pos   (wr_player_pos),
    .wr_bullet_pos   (wr_bullet_pos),
    .wr_bullet_color (wr_bullet_color),
    .wr_is_render    (wr_is_render),
    .wr_state        (wr_state),
    .act_player_pos  (act_player_pos),
    .act_bullet_pos  (act_bullet_pos),
    .act_bullet_color(act_bullet_color),
    .act_is_render   (act_is_render),
    .act_state       (act_state),
    .pending         (pending),
    .frame_tick      (frame_tick),
    .frame_cnt       (frame_cnt),
    .stale_cnt       (stale_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] player;
    logic [15:0] bullet;
    logic [1:0]  color;
    logic        rnd;
    logic [31:0] state;
  } pset_t;

  typedef struct packed {
    pset_t      act;
    logic [7:0] fcnt;
    logic [3:0] stale;
  } exp_t;

  exp_t  sb[$];
  int    checks;
  int    errors;

  // reference model
  pset_t      m_shadow;
  pset_t      m_act;
  logic       m_pending;
  logic [7:0] m_fcnt;
  logic [3:0] m_stale;

  pset_t last_act;
  pset_t cur_act;
  assign cur_act = {act_player_pos, act_bullet_pos, act_bullet_color, act_is_render, act_state};

  task automatic chk(input string name, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: compare against scoreboard on each tick; act_* must hold otherwise
  always @(negedge clk) begin
    if (reset) begin
      last_act = cur_act;
    end else if (frame_tick) begin
      exp_t e;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tick: got frame_tick=1 expected no tick");
      end else begin
        e = sb.pop_front();
        chk("tick_act_player", 80'(act_player_pos), 80'(e.act.player));
        chk("tick_act_bullet", 80'(act_bullet_pos), 80'(e.act.bullet));
        chk("tick_act_color", 80'(act_bullet_color), 80'(e.act.color));
        chk("tick_act_render", 80'(act_is_render), 80'(e.act.rnd));
        chk("tick_act_state", 80'(act_state), 80'(e.act.state));
        chk("tick_pending", 80'(pending), 80'(0));
        chk("tick_frame_cnt", 80'(frame_cnt), 80'(e.fcnt));
        chk("tick_stale_cnt", 80'(stale_cnt), 80'(e.stale));
      end
      last_act = cur_act;
    end else begin
      chk("act_stable", 80'(cur_act), 80'(last_act));
      last_act = cur_act;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_shadow  = '0;
    m_act     = '0;
    m_pending = 1'b0;
    m_fcnt    = 8'd0;
    m_stale   = 4'd0;
  endtask

  task automatic model_vblank();
    exp_t e;
    if (m_pending) begin
      m_act     = m_shadow;
      m_pending = 1'b0;
      m_stale   = 4'd0;
    end else if (m_stale != 4'hF) begin
      m_stale = m_stale + 4'd1;
    end
    m_fcnt  = m_fcnt + 8'd1;
    e.act   = m_act;
    e.fcnt  = m_fcnt;
    e.stale = m_stale;
    sb.push_back(e);
  endtask

  task automatic drive_set(input pset_t p);
    wr_player_pos   = p.player;
    wr_bullet_pos   = p.bullet;
    wr_bullet_color = p.color;
    wr_is_render    = p.rnd;
    wr_state        = p.state;
  endtask

  // One accepted write; caller guarantees y produces no edge this cycle
  task automatic wr(input pset_t p);
    drive_set(p);
    wr_valid = 1'b1;
    @(negedge clk);
    chk("wr_ready_idle", 80'(wr_ready), 80'(1));
    cyc();
    wr_valid  = 1'b0;
    m_shadow  = p;
    m_pending = 1'b1;
  endtask

  // One vblank entry: a visible line, then the crossing to line 480
  task automatic frame();
    y = 10'd100;
    cyc();
    y = 10'd480;
    model_vblank();
    cyc();
    cyc();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_pending", 80'(pending), 80'(0));
    chk("rst_act_player", 80'(act_player_pos), 80'(0));
    chk("rst_act_state", 80'(act_state), 80'(0));
    chk("rst_frame_tick", 80'(frame_tick), 80'(0));
    chk("rst_frame_cnt", 80'(frame_cnt), 80'(0));
    chk("rst_stale_cnt", 80'(stale_cnt), 80'(0));
    cyc();
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    pset_t p;
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    y        = 10'd0;
    wr_valid = 1'b0;
    drive_set('0);
    model_reset();
    last_act = '0;
    cyc();
    do_reset();

    // 1: single write committed at vblank
    y = 10'd100;
    cyc();
    p = '{player:16'h1020, bullet:16'h0000, color:2'd1, rnd:1'b1, state:32'h9000_6432};
    wr(p);
    chk("t1_pending_set", 80'(pending), 80'(1));
    chk("t1_act_hold", 80'(act_player_pos), 80'(16'h0000));
    frame();
    chk("t1_act_player", 80'(act_player_pos), 80'(16'h1020));
    chk("t1_act_state", 80'(act_state), 80'(32'h9000_6432));
    chk("t1_frame_cnt", 80'(frame_cnt), 80'(1));
    chk("t1_pending_clr", 80'(pending), 80'(0));

    // 2: last write in a frame wins
    p.bullet = 16'h0505;
    wr(p);
    p.bullet = 16'h0A0A;
    p.color  = 2'd3;
    wr(p);
    frame();
    chk("t2_act_bullet", 80'(act_bullet_pos), 80'(16'h0A0A));

    // 3: write offered on the edge cycle is held off one cycle
    y = 10'd100;
    cyc();
    y = 10'd480;
    p.bullet = 16'h3333;
    drive_set(p);
    wr_valid = 1'b1;
    model_vblank();
    @(negedge clk);
    chk("t3_ready_low_on_edge", 80'(wr_ready), 80'(0));
    cyc();
    @(negedge clk);
    chk("t3_ready_after_edge", 80'(wr_ready), 80'(1));
    cyc();
    wr_valid  = 1'b0;
    m_shadow  = p;
    m_pending = 1'b1;
    chk("t3_pending", 80'(pending), 80'(1));
    chk("t3_not_committed", 80'(act_bullet_pos), 80'(16'h0A0A));
    chk("t3_stale_one", 80'(stale_cnt), 80'(1));
    frame();
    chk("t3_committed_next", 80'(act_bullet_pos), 80'(16'h3333));

    // 4: stale counter saturates; y wrap is not an edge
    do_reset();
    for (int i = 0; i < 20; i++) frame();
    chk("t4_stale_sat", 80'(stale_cnt), 80'(15));
    chk("t4_act_zero", 80'(act_state), 80'(0));
    y = 10'd524;
    cyc();
    y = 10'd0;
    cyc();
    cyc();
    chk("t4_wrap_no_tick", 80'(frame_cnt), 80'(20));
    p = '{player:16'h0101, bullet:16'h0202, color:2'd2, rnd:1'b0, state:32'h0000_0001};
    wr(p);
    frame();
    chk("t4_stale_clear", 80'(stale_cnt), 80'(0));

    // 5: frame counter wraps after 256 frames
    do_reset();
    for (int i = 0; i < 256; i++) frame();
    chk("t5_fcnt_wrap", 80'(frame_cnt), 80'(0));

    // 6: reset mid-frame discards a pending set
    p = '{player:16'h4444, bullet:16'h5555, color:2'd1, rnd:1'b1, state:32'hDEAD_BEEF};
    y = 10'd300;
    cyc();
    wr(p);
    frame();
    chk("t6_pre_commit", 80'(act_state), 80'(32'hDEAD_BEEF));
    y = 10'd300;
    cyc();
    p.state = 32'h1234_5678;
    wr(p);
    chk("t6_pending_before", 80'(pending), 80'(1));
    #3;
    do_reset();
    y = 10'd300;
    cyc();
    frame();
    chk("t6_stale_one", 80'(stale_cnt), 80'(1));
    chk("t6_act_zero", 80'(act_state), 80'(0));
    chk("t6_pending_zero", 80'(pending), 80'(0));

    cyc();
    chk("sb_drained", 80'(sb.size()), 80'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
